// File: rtl/counter_4bit_pkg.sv
// Shared definitions for cascadable counter stages: default stage width and count type.
package counter_4bit_pkg;

    localparam int COUNT_WIDTH = 4;

    typedef logic [COUNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/counter_4bit.sv
// Synchronous modulo-(MAX+1) up-counter with count enable and combinational carry out,
// intended to be chained cout -> cin with all stages on one clock.
module counter_4bit
    import counter_4bit_pkg::*;
#(
    parameter int WIDTH = COUNT_WIDTH,
    parameter longint unsigned MAX = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cin,
    output logic [WIDTH-1:0] q,
    output logic             cout
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("counter_4bit: WIDTH must be in 1..32");
    end

    if (MAX < 64'd1 || MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("counter_4bit: MAX must be in 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_Q = MAX[WIDTH-1:0];

    // Using >= rather than == lets an out-of-range power-up value recover to 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (cin) begin
            if (q >= MAX_Q) begin
                q <= '0;
            end else begin
                q <= q + WIDTH'(1);
            end
        end
    end

    assign cout = cin & (q == MAX_Q);

`ifndef SYNTHESIS
    logic seen_reset = 1'b0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            seen_reset <= 1'b1;
        end
    end

    a_q_in_range: assert property (@(posedge clk) seen_reset |-> (q <= MAX_Q));
`endif

endmodule

// File: tb/tb_counter_4bit.sv
// Self-checking bench: a default 0..15 stage and a decade (MAX=9) stage driven in lockstep.
module tb_counter_4bit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cin = 1'b0;
    logic [3:0] q_a;
    logic [3:0] q_b;
    logic       cout_a;
    logic       cout_b;

    int checks = 0;
    int failures = 0;

    // reference counts, meaningful once a reset edge has been seen
    int  model_a = 0;
    int  model_b = 0;
    bit  synced = 1'b0;
    logic [3:0] exp_q[$];

    always #50 clk = ~clk;

    counter_4bit #(.WIDTH(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .cin   (cin),
        .q     (q_a),
        .cout  (cout_a)
    );

    counter_4bit #(.WIDTH(4), .MAX(9)) dut_b (
        .clk   (clk),
        .reset (reset),
        .cin   (cin),
        .q     (q_b),
        .cout  (cout_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs mid-cycle, check cout before the edge, q after it.
    task automatic step(input logic r, input logic c);
        @(negedge clk);
        reset = r;
        cin = c;
        #1;
        if (synced) begin
            check_val("cout_a", {31'd0, cout_a}, {31'd0, (c && model_a == 15)});
            check_val("cout_b", {31'd0, cout_b}, {31'd0, (c && model_b == 9)});
        end
        @(posedge clk);
        if (!r) begin
            model_a = 0;
            model_b = 0;
            synced = 1'b1;
        end else if (c) begin
            model_a = (model_a + 1) % 16;
            model_b = (model_b + 1) % 10;
        end
        if (synced) begin
            exp_q.push_back(4'(model_a));
            exp_q.push_back(4'(model_b));
            #1;
            check_val("q_a", {28'd0, q_a}, {28'd0, exp_q.pop_front()});
            check_val("q_b", {28'd0, q_b}, {28'd0, exp_q.pop_front()});
        end
    endtask

    task automatic run(input int n, input logic r, input logic c);
        for (int i = 0; i < n; i++) begin
            step(r, c);
        end
    endtask

    initial begin
        // reset with and without enable
        run(2, 1'b0, 1'b0);
        run(2, 1'b0, 1'b1);
        // count through a wrap: 0..15,0..3 then on to 6
        run(22, 1'b1, 1'b1);
        // hold at 6, then resume to 7
        run(3, 1'b1, 1'b0);
        run(1, 1'b1, 1'b1);
        // advance to 9, reset mid-count with cin high, resume to 1
        run(2, 1'b1, 1'b1);
        run(1, 1'b0, 1'b1);
        run(1, 1'b1, 1'b1);
        // advance to 15, hold there, then wrap with cout high immediately
        run(14, 1'b1, 1'b1);
        run(2, 1'b1, 1'b0);
        run(1, 1'b1, 1'b1);
        // decade stage: a full period from a clean reset
        run(1, 1'b0, 1'b0);
        run(25, 1'b1, 1'b1);
        // randomized phase
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
